// File: rtl/mem_burst_pkg.sv
// Shared types and default sizes for the sequential memory burst reader.
package mem_burst_pkg;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_LEN_W  = 8;
   localparam int FIFO_DEPTH = 2;
   localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_DONE
   } state_e;
endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO holding returned read data; entry 0 is always the head.
module rd_skid_fifo
   import mem_burst_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic [DATA_W-1:0]     din_i,
   input  logic                  pop_i,
   output logic [DATA_W-1:0]     dout_o,
   output logic [FIFO_CNT_W-1:0] count_o
);
   localparam logic [FIFO_CNT_W-1:0] CNT_ONE = FIFO_CNT_W'(1);

   logic [DATA_W-1:0]     e0_q, e0_d, e1_q, e1_d;
   logic [FIFO_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      case ({push_i, pop_i})
         2'b10: begin
            if (cnt_q == '0) e0_d = din_i;
            else             e1_d = din_i;
            cnt_d = cnt_q + CNT_ONE;
         end
         2'b01: begin
            e0_d  = e1_q;
            cnt_d = cnt_q - CNT_ONE;
         end
         2'b11: begin
            // Count is unchanged; the new word lands behind whatever remains.
            if (cnt_q == CNT_ONE) begin
               e0_d = din_i;
            end else begin
               e0_d = e1_q;
               e1_d = din_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= '0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign dout_o  = e0_q;
   assign count_o = cnt_q;
endmodule

// File: rtl/mem_burst_reader.sv
// Burst read engine: walks addr..addr+len-1 and streams words through a credit-guarded 2-entry buffer.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_FETCH | issuing reads while credit allows
//   ST_DRAIN | all reads issued, emptying buffer
//   ST_DONE  | one-cycle completion pulse
module mem_burst_reader
   import mem_burst_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);
   state_e                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q, addr_d, last_addr_q;
   logic [LEN_W-1:0]      rem_q, rem_d;
   logic                  inflight_q;
   logic                  issue, pop, credit_ok;
   logic [FIFO_CNT_W-1:0] fifo_count;
   logic [2:0]            credit_sum;

   assign out_valid  = (fifo_count != '0);
   assign pop        = out_valid & out_ready;
   assign credit_sum = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
   assign credit_ok  = (credit_sum < 3'd2);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      issue   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d  = start_addr;
               rem_d   = length;
               state_d = (length != '0) ? ST_FETCH : ST_DONE;
            end
         end
         ST_FETCH: begin
            if (credit_ok) begin
               issue  = 1'b1;
               addr_d = addr_q + ADDR_W'(1);
               rem_d  = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!inflight_q && (fifo_count == FIFO_CNT_W'(pop))) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         inflight_q  <= 1'b0;
         last_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         inflight_q <= issue;
         if (issue) last_addr_q <= addr_q;
      end
   end

   // The address bus shows the live pointer only while strobing, otherwise the last issued one.
   assign mem_rd_en = issue;
   assign mem_addr  = issue ? addr_q : last_addr_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);

   rd_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .push_i  (inflight_q),
      .din_i   (mem_rdata),
      .pop_i   (pop),
      .dout_o  (out_data),
      .count_o (fifo_count)
   );
endmodule
